pixel_axis_packer: RTL and testbench

//  Sits between the Hawk/Owl camera controllers and the S2MM DMA stream port. Takes
//  per-beat 12-bit pixel groups (Hawk: 2 px/beat, Owl: 4 px/beat), zero-extends

---
 rtl/pixel_axis_packer.sv | 153 +++++++++++++++
 tb/tb_pixel_axis_packer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_axis_packer.sv
// Packs 12-bit camera pixel groups (Hawk 2 px/beat, Owl 4 px/beat) into 64-bit
// AXI-Stream words of 16-bit pixels, buffered by a FWFT FIFO that absorbs DMA stalls.
module pixel_axis_packer #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 32
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             frame_rst,
    input  logic [47:0]      data_in,
    input  logic             data_vld,
    input  logic             data_end,
    input  logic             data_sel,
    output logic [63:0]      m_axis_tdata,
    output logic [7:0]       m_axis_tkeep,
    output logic             m_axis_tlast,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [CNT_W-1:0] word_cnt,
    output logic             overflow
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PW    = AW + 1;
    localparam int ENT_W = 1 + 8 + 64;

    typedef enum logic {HALF_EMPTY, HALF_PEND} half_t;

    function automatic logic [15:0] expand(input logic [11:0] px);
        return {4'h0, px};
    endfunction

    function automatic logic [31:0] expand2(input logic [23:0] px2);
        return {expand(px2[23:12]), expand(px2[11:0])};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    logic              clr;
    logic              sel_q;
    half_t             half_q, half_d;
    logic [31:0]       lo_p0;
    logic              lo_load;
    logic              wr_en;
    logic [ENT_W-1:0]  wr_data;

    logic [ENT_W-1:0]  mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr, rd_ptr_nxt;
    logic              full, rd_en, wr_ok, drop;

    assign clr = sys_rst | frame_rst;

    // Stage p0: word assembly from the incoming beat and any held low half
    always_comb begin
        half_d  = half_q;
        lo_load = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        if (!clr) begin
            if (sel_q) begin
                if (data_vld) begin
                    wr_en   = 1'b1;
                    wr_data = {data_end, 8'hFF, expand2(data_in[47:24]), expand2(data_in[23:0])};
                end
            end else if (data_vld) begin
                if (half_q == HALF_EMPTY) begin
                    if (data_end) begin
                        wr_en   = 1'b1;
                        wr_data = {1'b1, 8'h0F, 32'h0, expand2(data_in[23:0])};
                    end else begin
                        lo_load = 1'b1;
                        half_d  = HALF_PEND;
                    end
                end else begin
                    wr_en   = 1'b1;
                    wr_data = {data_end, 8'hFF, expand2(data_in[23:0]), lo_p0};
                    half_d  = HALF_EMPTY;
                end
            end else if (data_end && half_q == HALF_PEND) begin
                wr_en   = 1'b1;
                wr_data = {1'b1, 8'h0F, 32'h0, lo_p0};
                half_d  = HALF_EMPTY;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (clr) begin
            half_q <= HALF_EMPTY;
        end else begin
            half_q <= half_d;
        end
        if (sys_rst) begin
            sel_q <= 1'b0;
        end else if (frame_rst) begin
            sel_q <= data_sel;
        end
        if (lo_load) begin
            lo_p0 <= expand2(data_in[23:0]);
        end
    end

    // Stage p1: FIFO storage; a write at full is only legal when a read frees a slot
    assign full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign rd_en      = m_axis_tvalid & m_axis_tready;
    assign wr_ok      = wr_en & (~full | rd_en);
    assign drop       = wr_en & full & ~rd_en;
    assign rd_ptr_nxt = rd_ptr + PW'(rd_en);

    always_ff @(posedge sys_clk) begin
        if (wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr_nxt;
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Stage p2: output register only sees words written on an earlier edge
    always_ff @(posedge sys_clk) begin
        if (clr) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tkeep  <= '0;
            m_axis_tdata  <= '0;
            word_cnt      <= '0;
        end else begin
            m_axis_tvalid <= (wr_ptr != rd_ptr_nxt);
            if (wr_ptr != rd_ptr_nxt) begin
                {m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= mem[rd_ptr_nxt[AW-1:0]];
            end
            if (rd_en) begin
                word_cnt <= sat_inc(word_cnt);
            end
        end
    end

endmodule

// File: tb/tb_pixel_axis_packer.sv
// Self-checking bench for pixel_axis_packer: vector table, directed corner cases,
// and randomized frames against a pixel-list reference model.
module tb_pixel_axis_packer;

    logic        clk = 1'b0;
    logic        sys_rst, frame_rst, data_vld, data_end, data_sel;
    logic [47:0] data_in;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast, m_axis_tvalid, m_axis_tready;
    logic [31:0] word_cnt;
    logic        overflow;

    logic rdy_rand = 1'b0, rdy_r = 1'b0, rdy_fix = 1'b1;
    assign m_axis_tready = rdy_rand ? rdy_r : rdy_fix;

    int total = 0, bad = 0;
    logic [72:0] got[$];

    pixel_axis_packer #(.FIFO_DEPTH(16), .CNT_W(32)) dut (
        .sys_clk(clk), .sys_rst(sys_rst), .frame_rst(frame_rst),
        .data_in(data_in), .data_vld(data_vld), .data_end(data_end), .data_sel(data_sel),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .word_cnt(word_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk); #1;
        rdy_r = 1'($urandom_range(0, 1));
    end

    initial forever begin
        @(negedge clk);
        if (m_axis_tvalid && m_axis_tready) got.push_back({m_axis_tlast, m_axis_tkeep, m_axis_tdata});
    end

    task automatic chk(input string nm, input logic [72:0] act, input logic [72:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic beat(input logic [47:0] d, input logic e);
        data_in = d; data_vld = 1'b1; data_end = e;
        tick();
        data_vld = 1'b0; data_end = 1'b0;
    endtask

    task automatic frst(input logic sel);
        frame_rst = 1'b1; data_sel = sel;
        tick();
        frame_rst = 1'b0;
        got.delete();
    endtask

    task automatic wait_drain(input int n);
        int c = 0;
        while (got.size() < n && c < 3000) begin tick(); c++; end
        if (got.size() < n) chk("drain_timeout", 73'(got.size()), 73'(n));
        repeat (3) tick();
    endtask

    function automatic logic [47:0] ow(input logic [11:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic logic [47:0] hk(input logic [11:0] p0, p1);
        return {24'h0, p1, p0};
    endfunction

    typedef struct {
        logic        sel;
        int          nb;
        logic [47:0] b0, b1, b2;
        int          nw;
        logic [72:0] w0, w1;
    } vec_t;

    vec_t vt[5];

    initial begin
        logic [72:0] exp_q[$];
        logic [15:0] pix[$];
        logic [47:0] d;
        logic        sel;
        int          nb, np;

        sys_rst = 1'b1; frame_rst = 1'b0; data_vld = 1'b0; data_end = 1'b0;
        data_sel = 1'b0; data_in = '0;
        repeat (3) tick();
        sys_rst = 1'b0;
        chk("reset_out", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata},
            {1'b0, 1'b0, 8'h00, 64'h0});
        chk("reset_cnt_ovf", {word_cnt, overflow}, 73'h0);

        vt[0] = '{1'b1, 1, ow(12'h0, 12'h1, 12'h2, 12'h3), 48'h0, 48'h0, 1,
                  {1'b1, 8'hFF, 64'h0003_0002_0001_0000}, 73'h0};
        vt[1] = '{1'b0, 3, hk(12'h1, 12'h2), hk(12'h3, 12'h4), hk(12'h5, 12'h6), 2,
                  {1'b0, 8'hFF, 64'h0004_0003_0002_0001}, {1'b1, 8'h0F, 64'h0000_0000_0006_0005}};
        vt[2] = '{1'b0, 2, hk(12'hFFF, 12'h0), hk(12'hABC, 12'h123), 48'h0, 1,
                  {1'b1, 8'hFF, 64'h0123_0ABC_0000_0FFF}, 73'h0};
        vt[3] = '{1'b0, 1, hk(12'h800, 12'h7FF), 48'h0, 48'h0, 1,
                  {1'b1, 8'h0F, 64'h0000_0000_07FF_0800}, 73'h0};
        vt[4] = '{1'b1, 2, ow(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF), ow(12'h1, 12'h0, 12'h0, 12'h0), 48'h0, 2,
                  {1'b0, 8'hFF, 64'h0FFF_0FFF_0FFF_0FFF}, {1'b1, 8'hFF, 64'h0000_0000_0000_0001}};

        foreach (vt[i]) begin
            frst(vt[i].sel);
            for (int b = 0; b < vt[i].nb; b++)
                beat((b == 0) ? vt[i].b0 : (b == 1) ? vt[i].b1 : vt[i].b2, b == vt[i].nb - 1);
            wait_drain(vt[i].nw);
            chk($sformatf("vec%0d_count", i), 73'(got.size()), 73'(vt[i].nw));
            if (got.size() >= 1) chk($sformatf("vec%0d_w0", i), got[0], vt[i].w0);
            if (vt[i].nw > 1 && got.size() >= 2) chk($sformatf("vec%0d_w1", i), got[1], vt[i].w1);
            chk($sformatf("vec%0d_word_cnt", i), 73'(word_cnt), 73'(vt[i].nw));
        end

        // Owl frame of four beats, px = n*4+k
        frst(1'b1);
        for (int n = 0; n < 4; n++)
            beat(ow(12'(n*4), 12'(n*4+1), 12'(n*4+2), 12'(n*4+3)), n == 3);
        wait_drain(4);
        for (int n = 0; n < 4 && n < got.size(); n++)
            chk($sformatf("owl4_w%0d", n), got[n],
                {n == 3, 8'hFF, 16'(n*4+3), 16'(n*4+2), 16'(n*4+1), 16'(n*4)});
        chk("owl4_word_cnt", 73'(word_cnt), 73'd4);

        // Back-pressure: 18 Owl beats into a stalled 16-deep FIFO
        rdy_fix = 1'b0;
        frst(1'b1);
        exp_q.delete();
        for (int n = 0; n < 18; n++) begin
            d = {$urandom, $urandom};
            beat(d, 1'b0);
            exp_q.push_back({1'b0, 8'hFF, 4'h0, d[47:36], 4'h0, d[35:24], 4'h0, d[23:12], 4'h0, d[11:0]});
            if (n == 15) chk("ovf_before_17", 73'(overflow), 73'd0);
            if (n == 16) chk("ovf_after_17", 73'(overflow), 73'd1);
        end
        repeat (3) begin
            @(negedge clk);
            chk("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, {1'b1, exp_q[0]});
        end
        tick();
        rdy_fix = 1'b1;
        wait_drain(16);
        repeat (5) tick();
        chk("bp_count", 73'(got.size()), 73'd16);
        for (int n = 0; n < 16 && n < got.size(); n++)
            if (got[n] !== exp_q[n]) chk($sformatf("bp_order_w%0d", n), got[n], exp_q[n]);
        chk("bp_word_cnt", 73'(word_cnt), 73'd16);

        // frame_rst mid-frame with a half pending and five words buffered
        frst(1'b0);
        beat(hk(12'h1, 12'h2), 1'b0);
        beat(hk(12'h3, 12'h4), 1'b0);
        wait_drain(1);
        rdy_fix = 1'b0;
        for (int n = 0; n < 11; n++) beat(hk(12'(n), 12'(n + 100)), 1'b0);
        repeat (3) tick();
        chk("pre_frst_vld", 73'(m_axis_tvalid), 73'd1);
        frst(1'b0);
        chk("frst_clears", {m_axis_tvalid, word_cnt, overflow}, 73'h0);
        rdy_fix = 1'b1;
        beat(hk(12'h7, 12'h8), 1'b0);
        beat(hk(12'h9, 12'hA), 1'b1);
        wait_drain(1);
        chk("frst_count", 73'(got.size()), 73'd1);
        if (got.size() >= 1) chk("frst_lowhalf", got[0], {1'b1, 8'hFF, 64'h000A_0009_0008_0007});

        // frame_rst with data_vld drops the beat; later data_sel changes are ignored
        frame_rst = 1'b1; data_sel = 1'b1; data_in = ow(12'hBAD, 12'hBAD, 12'hBAD, 12'hBAD); data_vld = 1'b1;
        tick();
        frame_rst = 1'b0; data_vld = 1'b0; data_sel = 1'b0;
        got.delete();
        beat(ow(12'h11, 12'h22, 12'h33, 12'h44), 1'b0);
        beat(ow(12'h55, 12'h66, 12'h77, 12'h88), 1'b1);
        wait_drain(2);
        chk("sel_count", 73'(got.size()), 73'd2);
        if (got.size() >= 2) begin
            chk("sel_w0", got[0], {1'b0, 8'hFF, 64'h0044_0033_0022_0011});
            chk("sel_w1", got[1], {1'b1, 8'hFF, 64'h0088_0077_0066_0055});
        end

        // data_end alone: flushes a pending half, otherwise nothing
        frst(1'b0);
        beat(hk(12'h1, 12'h2), 1'b0);
        data_end = 1'b1; tick(); data_end = 1'b0;
        wait_drain(1);
        if (got.size() >= 1) chk("end_flush", got[0], {1'b1, 8'h0F, 64'h0000_0000_0002_0001});
        data_end = 1'b1; tick(); data_end = 1'b0;
        repeat (6) tick();
        chk("end_idle_count", 73'(got.size()), 73'd1);
        chk("end_idle_cnt", 73'(word_cnt), 73'd1);

        // Randomized frames with random ready against the pixel-list model
        rdy_rand = 1'b1;
        for (int f = 0; f < 24; f++) begin
            sel = 1'($urandom_range(0, 1));
            nb  = $urandom_range(1, 12);
            frst(sel);
            pix.delete(); exp_q.delete();
            for (int b = 0; b < nb; b++) begin
                d = {$urandom, $urandom};
                for (int k = 0; k < (sel ? 4 : 2); k++) pix.push_back({4'h0, d[12*k +: 12]});
                beat(d, b == nb - 1);
                repeat ($urandom_range(0, 2)) tick();
            end
            np = pix.size();
            for (int i = 0; i < np; i += 4) begin
                if (np - i >= 4)
                    exp_q.push_back({i + 4 >= np, 8'hFF, pix[i+3], pix[i+2], pix[i+1], pix[i]});
                else
                    exp_q.push_back({1'b1, 8'h0F, 32'h0, pix[i+1], pix[i]});
            end
            wait_drain(exp_q.size());
            chk($sformatf("rnd%0d_count", f), 73'(got.size()), 73'(exp_q.size()));
            for (int i = 0; i < exp_q.size() && i < got.size(); i++)
                if (got[i] !== exp_q[i]) chk($sformatf("rnd%0d_w%0d", f, i), got[i], exp_q[i]);
            chk($sformatf("rnd%0d_cnt_ovf", f), {word_cnt, overflow}, {32'(exp_q.size()), 1'b0});
        end
        rdy_rand = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
